// File: rtl/if_id_stage.sv
// if_id_stage: MIPS instruction fetch with IF/ID register, stall/flush handling and halt sequencer
module if_id_stage #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0] HLT_OP = 6'b000101
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc_next,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [31:0]       id_imm,
  output logic              halted
);
  typedef enum logic [1:0] {RUN, HOLD, HALTED} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc_inc;
  logic bubble, fetch;
  assign pc_inc = pc + 1'b1;
  // HOLD drains the HLT out of IF/ID but never fetches past it
  assign bubble = halt_i || branch_taken_i || (state == HOLD && !stall_i);
  assign fetch = !halt_i && !branch_taken_i && state == RUN && !stall_i;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc_next <= '0;
    end else if (state != HALTED) begin
      if (bubble) begin
        id_valid <= 1'b0;
        id_instr <= '0;
        id_pc_next <= '0;
      end else if (fetch) begin
        id_valid <= 1'b1;
        id_instr <= imem_rdata;
        id_pc_next <= pc_inc;
      end
      if (halt_i) state <= HALTED;
      else if (branch_taken_i) state <= RUN;
      else if (fetch && imem_rdata[31:26] == HLT_OP) state <= HOLD;
      if (!halt_i && branch_taken_i) pc <= branch_target_i;
      else if (fetch) pc <= pc_inc;
    end
  end
  assign imem_addr = pc;
  assign halted = state == HALTED;
  assign id_opcode = id_instr[31:26];
  assign id_rs = id_instr[25:21];
  assign id_rt = id_instr[20:16];
  assign id_rd = id_instr[15:11];
  assign id_imm = {{16{id_instr[15]}}, id_instr[15:0]};
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed and randomized checks of if_id_stage against a cycle-level reference model
module tb_if_id_stage;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n, stall_i, branch_taken_i, halt_i;
  logic [9:0] branch_target_i, imem_addr, pc, id_pc_next;
  logic [31:0] imem_rdata, id_instr, id_imm;
  logic id_valid, halted;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [31:0] imem [1024];
  assign imem_rdata = imem[imem_addr];
  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_i(stall_i), .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .halt_i(halt_i), .pc(pc), .id_valid(id_valid), .id_instr(id_instr), .id_pc_next(id_pc_next),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .halted(halted)
  );
  logic rst2_n, br2, val2, halted2;
  logic [3:0] tgt2, addr2, pc2, pcn2;
  logic [31:0] rdata2, instr2, imm2;
  logic [5:0] op2;
  logic [4:0] rs2, rt2, rd2;
  assign rdata2 = {28'h0100000, addr2};
  if_id_stage #(.ADDR_W(4), .RESET_PC(4'd0)) dut4 (
    .clk(clk), .rst_n(rst2_n), .imem_addr(addr2), .imem_rdata(rdata2),
    .stall_i(1'b0), .branch_taken_i(br2), .branch_target_i(tgt2),
    .halt_i(1'b0), .pc(pc2), .id_valid(val2), .id_instr(instr2), .id_pc_next(pcn2),
    .id_opcode(op2), .id_rs(rs2), .id_rt(rt2), .id_rd(rd2), .id_imm(imm2), .halted(halted2)
  );
  int tests = 0, fails = 0;
  int m_pc, m_pcn, m_mode;
  bit m_valid;
  logic [31:0] m_instr;
  function automatic logic [31:0] no_hlt(input logic [31:0] w);
    return (w[31:26] == 6'd5) ? {6'd6, w[25:0]} : w;
  endfunction
  task automatic cyc(input bit r, input bit s, input bit b, input int t, input bit h);
    logic [31:0] w;
    rst_n = r; stall_i = s; branch_taken_i = b; branch_target_i = 10'(t); halt_i = h;
    w = imem[m_pc];
    if (!r) begin m_pc = 0; m_mode = 0; m_valid = 0; m_instr = 0; m_pcn = 0; end
    else if (m_mode == 2) ;
    else if (h) begin m_mode = 2; m_valid = 0; m_instr = 0; end
    else if (b) begin m_pc = t; m_mode = 0; m_valid = 0; m_instr = 0; end
    else if (m_mode == 1) begin if (!s) begin m_valid = 0; m_instr = 0; end end
    else if (!s) begin
      m_instr = w; m_valid = 1; m_pcn = (m_pc + 1) % 1024; m_pc = m_pcn;
      if (w[31:26] == 6'd5) m_mode = 1;
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 7, 1);
    tests++;
    if (pc !== 0 || id_valid !== 0 || id_instr !== 0 || id_pc_next !== 0 || halted !== 0 ||
        id_opcode !== 0 || id_rs !== 0 || id_rt !== 0 || id_rd !== 0 || id_imm !== 0) begin
      fails++;
      $display("FAIL reset: pc=%0d v=%b instr=%h pcn=%0d halted=%b imm=%h, want all 0", pc, id_valid, id_instr, id_pc_next, halted, id_imm);
    end
  endtask
  task automatic test_free_run;
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) begin w[i] = no_hlt($urandom); imem[i] = w[i]; end
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0);
      tests++;
      if (id_instr !== w[i] || pc !== 10'(i + 1) || id_pc_next !== 10'(i + 1) || id_valid !== 1) begin
        fails++;
        $display("FAIL free_run[%0d]: instr=%h pc=%0d pcn=%0d v=%b, want %h %0d %0d 1", i, id_instr, pc, id_pc_next, id_valid, w[i], i + 1, i + 1);
      end
    end
  endtask
  task automatic test_fields;
    imem[0] = 32'h2443_FFFC; imem[1] = 32'h0000_7FFF;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (id_opcode !== 6'b001001 || id_rs !== 5'd2 || id_rt !== 5'd3 || id_rd !== 5'd31 || id_imm !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL fields: op=%b rs=%0d rt=%0d rd=%0d imm=%h, want 001001 2 3 31 fffffffc", id_opcode, id_rs, id_rt, id_rd, id_imm);
    end
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (id_imm !== 32'h0000_7FFF) begin
      fails++;
      $display("FAIL imm_pos: imm=%h, want 00007fff", id_imm);
    end
  endtask
  task automatic test_stall;
    logic [31:0] b, c;
    for (int i = 0; i < 4; i++) imem[i] = no_hlt($urandom);
    b = imem[1]; c = imem[2];
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0, 0);
      tests++;
      if (pc !== 10'd2 || id_instr !== b || id_valid !== 1) begin
        fails++;
        $display("FAIL stall[%0d]: pc=%0d instr=%h v=%b, want 2 %h 1", i, pc, id_instr, id_valid, b);
      end
    end
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (id_instr !== c || pc !== 10'd3) begin
      fails++;
      $display("FAIL stall_release: instr=%h pc=%0d, want %h 3", id_instr, pc, c);
    end
  endtask
  task automatic test_branch_stall;
    cyc(1, 1, 1, 'h20, 0);
    tests++;
    if (pc !== 10'h20 || id_valid !== 0 || id_instr !== 0) begin
      fails++;
      $display("FAIL branch_stall: pc=%h v=%b instr=%h, want 20 0 0", pc, id_valid, id_instr);
    end
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (id_instr !== imem[32] || id_valid !== 1 || pc !== 10'h21) begin
      fails++;
      $display("FAIL branch_fetch: instr=%h v=%b pc=%h, want %h 1 21", id_instr, id_valid, pc, imem[32]);
    end
  endtask
  task automatic run_to_hold;
    for (int i = 0; i < 12; i++) imem[i] = no_hlt($urandom);
    imem[5] = {6'd5, 26'($urandom)};
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0);
  endtask
  task automatic test_hlt_cancel;
    run_to_hold;
    tests++;
    if (pc !== 10'd6 || id_instr !== imem[5] || id_valid !== 1) begin
      fails++;
      $display("FAIL hlt_fetch: pc=%0d instr=%h v=%b, want 6 %h 1", pc, id_instr, id_valid, imem[5]);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (pc !== 10'd6 || id_valid !== 0 || id_instr !== 0 || halted !== 0) begin
      fails++;
      $display("FAIL hold: pc=%0d v=%b instr=%h halted=%b, want 6 0 0 0", pc, id_valid, id_instr, halted);
    end
    cyc(1, 0, 1, 9, 0);
    tests++;
    if (pc !== 10'd9 || id_valid !== 0 || halted !== 0) begin
      fails++;
      $display("FAIL hold_cancel: pc=%0d v=%b halted=%b, want 9 0 0", pc, id_valid, halted);
    end
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (pc !== 10'd10 || id_instr !== imem[9] || id_valid !== 1) begin
      fails++;
      $display("FAIL resume: pc=%0d instr=%h v=%b, want 10 %h 1", pc, id_instr, id_valid, imem[9]);
    end
  endtask
  task automatic test_halt;
    run_to_hold;
    cyc(1, 0, 0, 0, 1);
    tests++;
    if (halted !== 1 || pc !== 10'd6 || id_valid !== 0) begin
      fails++;
      $display("FAIL halt: halted=%b pc=%0d v=%b, want 1 6 0", halted, pc, id_valid);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1, i[0], i[1], $urandom_range(0, 1023), i[2]);
      tests++;
      if (halted !== 1 || pc !== 10'd6 || id_valid !== 0) begin
        fails++;
        $display("FAIL halted_frozen[%0d]: halted=%b pc=%0d v=%b, want 1 6 0", i, halted, pc, id_valid);
      end
    end
    cyc(0, 1, 1, 3, 0);
    tests++;
    if (pc !== 0 || halted !== 0 || id_valid !== 0) begin
      fails++;
      $display("FAIL halt_reset: pc=%0d halted=%b v=%b, want 0 0 0", pc, halted, id_valid);
    end
  endtask
  task automatic test_random;
    logic [31:0] x_imm;
    for (int i = 0; i < 1024; i++) begin
      imem[i] = $urandom;
      if ($urandom_range(0, 9) == 0) imem[i][31:26] = 6'd5;
    end
    cyc(0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 29) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 1023), $urandom_range(0, 39) == 0);
      x_imm = 32'(int'($signed(m_instr[15:0])));
      tests++;
      if (pc !== 10'(m_pc) || id_valid !== m_valid || id_instr !== m_instr || halted !== (m_mode == 2) ||
          (m_valid && id_pc_next !== 10'(m_pcn)) || id_imm !== x_imm || id_opcode !== m_instr[31:26]) begin
        fails++;
        $display("FAIL random[%0d]: pc=%0d v=%b instr=%h pcn=%0d halted=%b imm=%h, want %0d %b %h %0d %b %h",
                 n, pc, id_valid, id_instr, id_pc_next, halted, id_imm, m_pc, m_valid, m_instr, m_pcn, m_mode == 2, x_imm);
      end
    end
  endtask
  task automatic test_wrap;
    rst2_n = 0; br2 = 0; tgt2 = 0;
    @(posedge clk); #1;
    rst2_n = 1; br2 = 1; tgt2 = 4'd15;
    @(posedge clk); #1;
    tests++;
    if (pc2 !== 4'd15) begin
      fails++;
      $display("FAIL wrap_branch: pc=%0d, want 15", pc2);
    end
    br2 = 0;
    @(posedge clk); #1;
    tests++;
    if (pc2 !== 4'd0 || pcn2 !== 4'd0 || instr2 !== 32'h0100_000F || val2 !== 1) begin
      fails++;
      $display("FAIL wrap: pc=%0d pcn=%0d instr=%h v=%b, want 0 0 0100000f 1", pc2, pcn2, instr2, val2);
    end
  endtask
  initial begin
    rst_n = 0; stall_i = 0; branch_taken_i = 0; branch_target_i = 0; halt_i = 0;
    rst2_n = 0; br2 = 0; tgt2 = 0;
    m_pc = 0; m_pcn = 0; m_mode = 0; m_valid = 0; m_instr = 0;
    for (int i = 0; i < 1024; i++) imem[i] = no_hlt($urandom);
    test_reset;
    test_free_run;
    test_fields;
    test_stall;
    test_branch_stall;
    test_hlt_cancel;
    test_halt;
    test_random;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
